alarm_controller: RTL and testbench
===================================

Name: alarm_controller

Overview:
- Sequencing controller for the clock/alarm set datapath.
- Debounces the raw minute/hour push buttons into single-cycle increment strobes.
- Routes each strobe to either the clock-time or alarm-time BCD counters.
- Compares current time against alarm time and runs the buzzer ring/snooze state machine. Sits between the board buttons, the time and alarm set registers, and the buzzer output.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive identical samples needed to accept a button level change
RING_SECONDS, 60, sec_tick pulses the buzzer rings before auto-stop
SNOOZE_MIN, 5, snooze length in minutes (SNOOZE_MIN*60 sec_tick pulses)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
switch  in  1  1 = set mode (increments allowed, alarm suppressed)
sel_alarm  in  1  0 = buttons target clock time, 1 = target alarm time
push2  in  1  raw minute button, active-low
push3  in  1  raw hour button, active-low
snooze  in  1  raw snooze button, active-low
alarm_en  in  1  1 = alarm armed
sec_tick  in  1  one-cycle pulse per second
cur_h1, cur_h0, cur_m1, cur_m0  in  4 each  current time, BCD
al_h1, al_h0, al_m1, al_m0  in  4 each  alarm time, BCD
inc_min_clk, inc_hr_clk  out  1 each  one-cycle increment strobes to clock-time counters
inc_min_al, inc_hr_al  out  1 each  one-cycle increment strobes to alarm-time counters
buzzer  out  1  1 while ringing
snooze_active  out  1  1 while in SNOOZE
state  out  2  00 IDLE, 01 RINGING, 10 SNOOZE (11 unused, decodes to IDLE)

Behaviour:
- Reset (reset=0 at a clk edge):
  - All outputs 0; state IDLE.
  - Debouncers set to released; ring/snooze counters 0.
  - match_latch set to 1, so a time==alarm match present at reset release never rings.
- Debounce, per button:
  - Accepted level changes only after DEBOUNCE_CYCLES consecutive samples at the new level.
  - Press event = accepted 1->0 transition; exactly one event per press, no auto-repeat.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Strobe routing:
  - A push2/push3 press event in a cycle with switch=1 drives exactly one strobe high for one cycle, registered (one cycle after the event).
  - Destination is chosen by sel_alarm sampled in the event cycle.
  - Press with switch=0 produces no strobe and is discarded, not queued.
  - push2 and push3 events in the same cycle produce both minute and hour strobes.
- Match: match = (cur_h1,cur_h0,cur_m1,cur_m0) == (al_h1,al_h0,al_m1,al_m0). match_latch is set on entering RINGING and cleared whenever match=0.
- IDLE -> RINGING when alarm_en=1 & switch=0 & match=1 & match_latch=0. Ring counter loads 0.
- RINGING:
  - buzzer=1; ring counter increments on sec_tick.
  - Exit to IDLE at ring counter == RING_SECONDS-1 with sec_tick.
  - Exit to SNOOZE on a snooze press event; snooze counter loads SNOOZE_MIN*60.
  - Exit to IDLE if alarm_en=0 or switch=1.
- SNOOZE:
  - buzzer=0, snooze_active=1; counter decrements on sec_tick.
  - At counter==1 with sec_tick: go to RINGING, ring counter reloads 0.
  - alarm_en=0 or switch=1: go to IDLE.
- Priority in a single cycle: reset > (alarm_en=0 or switch=1) > snooze press > ring/snooze timeout.
- buzzer and snooze_active are registered, valid the cycle after the state change.
- Counter widths: ring $clog2(RING_SECONDS); snooze $clog2(SNOOZE_MIN*60+1). No wrap; counters saturate at their terminal value.
- Reset mid-ring or mid-snooze: return to IDLE with buzzer=0 on the next clk edge. Match is re-armed only after time != alarm.

Test Plan:
- Reset held 3 cycles, cur=al=00:00, alarm_en=1, switch=0 -> buzzer stays 0 after release until time leaves and re-enters 00:00.
- switch=1, sel_alarm=1, push2 low 10 cycles with a 2-cycle glitch before it -> exactly one inc_min_al pulse, no inc_min_clk; same press with switch=0 -> no strobe.
- cur=07:30 equals al=07:30, alarm_en=1 -> buzzer=1, state=01; after 60 sec_tick pulses -> buzzer=0, state=00, no retrigger while still 07:30.
- Ringing, snooze pressed -> state=10, buzzer=0; 300 sec_tick pulses later -> state=01, buzzer=1.
- Ringing, alarm_en=0 and snooze press in same cycle -> state=00, snooze_active stays 0.
- push2 and push3 accepted in same cycle, switch=1, sel_alarm=0 -> inc_min_clk and inc_hr_clk both pulse for one cycle.

Source files
------------

// File: rtl/alarm_controller.sv
// Alarm sequencing: button debounce, set-strobe routing, time/alarm match and ring/snooze FSM.
// Strobes and buzzer/snooze_active are registered; buttons are active-low raw inputs.

module alarm_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic          level;
  logic [CW-1:0] cnt;

  // cnt counts consecutive samples that disagree with the accepted level
  always_ff @(posedge clk) begin
    if (!reset) begin
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (raw == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= raw;
        cnt   <= '0;
        press <= ~raw;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module alarm_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RING_SECONDS    = 60,
  parameter int SNOOZE_MIN      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       switch,
  input  logic       sel_alarm,
  input  logic       push2,
  input  logic       push3,
  input  logic       snooze,
  input  logic       alarm_en,
  input  logic       sec_tick,
  input  logic [3:0] cur_h1,
  input  logic [3:0] cur_h0,
  input  logic [3:0] cur_m1,
  input  logic [3:0] cur_m0,
  input  logic [3:0] al_h1,
  input  logic [3:0] al_h0,
  input  logic [3:0] al_m1,
  input  logic [3:0] al_m0,
  output logic       inc_min_clk,
  output logic       inc_hr_clk,
  output logic       inc_min_al,
  output logic       inc_hr_al,
  output logic       buzzer,
  output logic       snooze_active,
  output logic [1:0] state
);
  localparam int RW = $clog2(RING_SECONDS);
  localparam int SW = $clog2(SNOOZE_MIN * 60 + 1);
  localparam logic [RW-1:0] RING_LAST   = RW'(RING_SECONDS - 1);
  localparam logic [SW-1:0] SNOOZE_LOAD = SW'(SNOOZE_MIN * 60);
  localparam logic [SW-1:0] SNOOZE_ONE  = SW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RINGING = 2'b01,
    SNOOZE  = 2'b10
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic          min_press;
  logic          hr_press;
  logic          snz_press;
  logic          match;
  logic          match_latch;
  logic          abort;
  logic          enter_ring;
  logic          enter_snooze;
  logic [RW-1:0] ring_cnt;
  logic [SW-1:0] snz_cnt;

  alarm_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_min (
    .clk(clk), .reset(reset), .raw(push2), .press(min_press)
  );
  alarm_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_hr (
    .clk(clk), .reset(reset), .raw(push3), .press(hr_press)
  );
  alarm_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_snz (
    .clk(clk), .reset(reset), .raw(snooze), .press(snz_press)
  );

  assign match = ({cur_h1, cur_h0, cur_m1, cur_m0} == {al_h1, al_h0, al_m1, al_m0});
  assign abort = ~alarm_en | switch;

  // Encoding 11 is unreachable but falls into the IDLE branch
  always_comb begin
    state_d = state_q;
    case (state_q)
      RINGING: begin
        if (abort)                                 state_d = IDLE;
        else if (snz_press)                        state_d = SNOOZE;
        else if (sec_tick && ring_cnt == RING_LAST) state_d = IDLE;
      end
      SNOOZE: begin
        if (abort)                                 state_d = IDLE;
        else if (sec_tick && snz_cnt == SNOOZE_ONE) state_d = RINGING;
      end
      default: begin
        if (alarm_en && !switch && match && !match_latch) state_d = RINGING;
        else                                               state_d = IDLE;
      end
    endcase
  end

  assign enter_ring   = (state_d == RINGING) && (state_q != RINGING);
  assign enter_snooze = (state_d == SNOOZE) && (state_q != SNOOZE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      match_latch   <= 1'b1;
      ring_cnt      <= '0;
      snz_cnt       <= '0;
      buzzer        <= 1'b0;
      snooze_active <= 1'b0;
      inc_min_clk   <= 1'b0;
      inc_hr_clk    <= 1'b0;
      inc_min_al    <= 1'b0;
      inc_hr_al     <= 1'b0;
    end else begin
      state_q <= state_d;

      // A match only rings once; it must go away before it can ring again
      if (!match)          match_latch <= 1'b0;
      else if (enter_ring) match_latch <= 1'b1;

      if (enter_ring)
        ring_cnt <= '0;
      else if (state_q == RINGING && sec_tick && ring_cnt != RING_LAST)
        ring_cnt <= ring_cnt + 1'b1;

      if (enter_snooze)
        snz_cnt <= SNOOZE_LOAD;
      else if (state_q == SNOOZE && sec_tick && snz_cnt != '0)
        snz_cnt <= snz_cnt - 1'b1;

      buzzer        <= (state_q == RINGING);
      snooze_active <= (state_q == SNOOZE);

      inc_min_clk <= min_press & switch & ~sel_alarm;
      inc_hr_clk  <= hr_press  & switch & ~sel_alarm;
      inc_min_al  <= min_press & switch &  sel_alarm;
      inc_hr_al   <= hr_press  & switch &  sel_alarm;
    end
  end

  assign state = state_q;
endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: reset re-arm, debounce/routing, ring, snooze and priority.
module tb_alarm_controller;
  logic       clk = 1'b0;
  logic       reset, switch, sel_alarm, push2, push3, snooze, alarm_en, sec_tick;
  logic [3:0] cur_h1, cur_h0, cur_m1, cur_m0;
  logic [3:0] al_h1, al_h0, al_m1, al_m0;
  logic       inc_min_clk, inc_hr_clk, inc_min_al, inc_hr_al, buzzer, snooze_active;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;
  int c_min_clk, c_hr_clk, c_min_al, c_hr_al;

  always #5 clk = ~clk;

  alarm_controller dut (
    .clk(clk), .reset(reset), .switch(switch), .sel_alarm(sel_alarm),
    .push2(push2), .push3(push3), .snooze(snooze), .alarm_en(alarm_en),
    .sec_tick(sec_tick),
    .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
    .al_h1(al_h1), .al_h0(al_h0), .al_m1(al_m1), .al_m0(al_m0),
    .inc_min_clk(inc_min_clk), .inc_hr_clk(inc_hr_clk),
    .inc_min_al(inc_min_al), .inc_hr_al(inc_hr_al),
    .buzzer(buzzer), .snooze_active(snooze_active), .state(state)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_sec(input int n);
    repeat (n) begin
      sec_tick = 1'b1;
      step(1);
      sec_tick = 1'b0;
      step(1);
    end
  endtask

  task automatic set_time(input logic [3:0] h1, h0, m1, m0);
    cur_h1 = h1; cur_h0 = h0; cur_m1 = m1; cur_m0 = m0;
  endtask

  task automatic set_alarm(input logic [3:0] h1, h0, m1, m0);
    al_h1 = h1; al_h0 = h0; al_m1 = m1; al_m0 = m0;
  endtask

  task automatic clear_counts();
    c_min_clk = 0; c_hr_clk = 0; c_min_al = 0; c_hr_al = 0;
  endtask

  task automatic run_count(input int n);
    repeat (n) begin
      step(1);
      c_min_clk += int'(inc_min_clk);
      c_hr_clk  += int'(inc_hr_clk);
      c_min_al  += int'(inc_min_al);
      c_hr_al   += int'(inc_hr_al);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; alarm_en = 1'b1; switch = 1'b0;
    set_time(0, 0, 0, 0);
    set_alarm(0, 0, 0, 0);
    step(3);
    n_cmp++;
    if ({inc_min_clk, inc_hr_clk, inc_min_al, inc_hr_al, buzzer, snooze_active, state} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 00000000",
               {inc_min_clk, inc_hr_clk, inc_min_al, inc_hr_al, buzzer, snooze_active, state});
    end
    reset = 1'b1;
    step(10);
    n_cmp++;
    if ({buzzer, state} !== 3'b000) begin
      n_err++; $display("FAIL reset_no_ring: got buzzer/state %b expected 000", {buzzer, state});
    end
    set_time(0, 0, 0, 1);
    step(2);
    n_cmp++;
    if (state !== 2'b00) begin
      n_err++; $display("FAIL reset_nomatch_state: got %b expected 00", state);
    end
    set_time(0, 0, 0, 0);
    step(2);
    n_cmp++;
    if ({buzzer, state} !== 3'b101) begin
      n_err++; $display("FAIL rearm_ring: got buzzer/state %b expected 101", {buzzer, state});
    end
    switch = 1'b1;
    step(1);
    n_cmp++;
    if (state !== 2'b00) begin
      n_err++; $display("FAIL switch_abort_state: got %b expected 00", state);
    end
    step(1);
    n_cmp++;
    if (buzzer !== 1'b0) begin
      n_err++; $display("FAIL switch_abort_buzzer: got %b expected 0", buzzer);
    end
    switch = 1'b0;
    step(5);
    n_cmp++;
    if (state !== 2'b00) begin
      n_err++; $display("FAIL no_retrigger_after_abort: got %b expected 00", state);
    end
  endtask

  task automatic test_debounce_routing();
    set_time(1, 2, 0, 0);
    set_alarm(0, 7, 3, 0);
    switch = 1'b1; sel_alarm = 1'b1;
    clear_counts();
    push2 = 1'b0; run_count(2);
    push2 = 1'b1; run_count(3);
    push2 = 1'b0; run_count(10);
    push2 = 1'b1; run_count(8);
    n_cmp++;
    if (c_min_al !== 1) begin
      n_err++; $display("FAIL min_al_pulses: got %0d expected 1", c_min_al);
    end
    n_cmp++;
    if (c_min_clk + c_hr_clk + c_hr_al !== 0) begin
      n_err++; $display("FAIL min_al_other_strobes: got %0d expected 0", c_min_clk + c_hr_clk + c_hr_al);
    end
    switch = 1'b0;
    clear_counts();
    push2 = 1'b0; run_count(10);
    push2 = 1'b1; run_count(8);
    switch = 1'b1; run_count(6);
    n_cmp++;
    if (c_min_clk + c_hr_clk + c_min_al + c_hr_al !== 0) begin
      n_err++; $display("FAIL switch_off_discard: got %0d strobes expected 0",
                        c_min_clk + c_hr_clk + c_min_al + c_hr_al);
    end
    sel_alarm = 1'b0;
    clear_counts();
    push3 = 1'b0; run_count(10);
    push3 = 1'b1; run_count(8);
    n_cmp++;
    if ({c_hr_clk, c_min_clk, c_min_al, c_hr_al} !== {32'd1, 32'd0, 32'd0, 32'd0}) begin
      n_err++; $display("FAIL hr_clk_route: got hr_clk=%0d min_clk=%0d min_al=%0d hr_al=%0d expected 1/0/0/0",
                        c_hr_clk, c_min_clk, c_min_al, c_hr_al);
    end
    switch = 1'b0;
  endtask

  task automatic test_ring_timeout();
    alarm_en = 1'b1; switch = 1'b0;
    set_time(0, 7, 3, 0);
    set_alarm(0, 7, 3, 0);
    step(2);
    n_cmp++;
    if ({buzzer, state} !== 3'b101) begin
      n_err++; $display("FAIL ring_start: got buzzer/state %b expected 101", {buzzer, state});
    end
    tick_sec(59);
    n_cmp++;
    if ({buzzer, state} !== 3'b101) begin
      n_err++; $display("FAIL ring_59_ticks: got buzzer/state %b expected 101", {buzzer, state});
    end
    tick_sec(1);
    n_cmp++;
    if ({buzzer, state} !== 3'b000) begin
      n_err++; $display("FAIL ring_timeout: got buzzer/state %b expected 000", {buzzer, state});
    end
    step(10);
    n_cmp++;
    if ({buzzer, state} !== 3'b000) begin
      n_err++; $display("FAIL ring_no_retrigger: got buzzer/state %b expected 000", {buzzer, state});
    end
  endtask

  task automatic test_snooze();
    set_time(0, 7, 3, 1); step(2);
    set_time(0, 7, 3, 0); step(3);
    n_cmp++;
    if (state !== 2'b01) begin
      n_err++; $display("FAIL snooze_pre_ring: got %b expected 01", state);
    end
    snooze = 1'b0;
    step(8);
    n_cmp++;
    if ({state, buzzer, snooze_active} !== 4'b1001) begin
      n_err++; $display("FAIL snooze_enter: got state/buzzer/snz %b expected 1001",
                        {state, buzzer, snooze_active});
    end
    snooze = 1'b1;
    step(6);
    tick_sec(299);
    n_cmp++;
    if (state !== 2'b10) begin
      n_err++; $display("FAIL snooze_299_ticks: got %b expected 10", state);
    end
    tick_sec(1);
    n_cmp++;
    if ({state, buzzer, snooze_active} !== 4'b0110) begin
      n_err++; $display("FAIL snooze_expire: got state/buzzer/snz %b expected 0110",
                        {state, buzzer, snooze_active});
    end
  endtask

  task automatic test_abort_priority();
    bit seen_snz;
    snooze = 1'b0;
    step(4);
    alarm_en = 1'b0;
    step(1);
    n_cmp++;
    if (state !== 2'b00) begin
      n_err++; $display("FAIL abort_over_snooze_state: got %b expected 00", state);
    end
    seen_snz = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (snooze_active) seen_snz = 1'b1;
    end
    n_cmp++;
    if ({seen_snz, buzzer} !== 2'b00) begin
      n_err++; $display("FAIL abort_over_snooze_outputs: got snz_seen/buzzer %b expected 00",
                        {seen_snz, buzzer});
    end
    snooze = 1'b1;
    step(6);
    alarm_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    int idx_min, idx_hr;
    switch = 1'b1; sel_alarm = 1'b0;
    clear_counts();
    idx_min = -1; idx_hr = -1;
    push2 = 1'b0; push3 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (inc_min_clk) begin c_min_clk++; idx_min = i; end
      if (inc_hr_clk)  begin c_hr_clk++;  idx_hr  = i; end
      c_min_al += int'(inc_min_al);
      c_hr_al  += int'(inc_hr_al);
    end
    push2 = 1'b1; push3 = 1'b1;
    run_count(8);
    n_cmp++;
    if ({c_min_clk, c_hr_clk} !== {32'd1, 32'd1}) begin
      n_err++; $display("FAIL both_strobes_count: got min=%0d hr=%0d expected 1/1", c_min_clk, c_hr_clk);
    end
    n_cmp++;
    if (idx_min !== 5 || idx_hr !== 5) begin
      n_err++; $display("FAIL both_strobes_cycle: got min@%0d hr@%0d expected 5/5", idx_min, idx_hr);
    end
    n_cmp++;
    if (c_min_al + c_hr_al !== 0) begin
      n_err++; $display("FAIL both_strobes_al: got %0d expected 0", c_min_al + c_hr_al);
    end
    switch = 1'b0;
  endtask

  task automatic test_reset_mid_ring();
    set_time(0, 7, 3, 1); step(2);
    set_time(0, 7, 3, 0); step(3);
    n_cmp++;
    if ({buzzer, state} !== 3'b101) begin
      n_err++; $display("FAIL midring_pre: got buzzer/state %b expected 101", {buzzer, state});
    end
    reset = 1'b0;
    step(1);
    n_cmp++;
    if ({buzzer, state} !== 3'b000) begin
      n_err++; $display("FAIL midring_reset: got buzzer/state %b expected 000", {buzzer, state});
    end
    reset = 1'b1;
    step(8);
    n_cmp++;
    if ({buzzer, state} !== 3'b000) begin
      n_err++; $display("FAIL midring_no_rering: got buzzer/state %b expected 000", {buzzer, state});
    end
    set_time(0, 7, 3, 1); step(2);
    set_time(0, 7, 3, 0); step(3);
    n_cmp++;
    if ({buzzer, state} !== 3'b101) begin
      n_err++; $display("FAIL midring_rearm: got buzzer/state %b expected 101", {buzzer, state});
    end
  endtask

  initial begin
    reset = 1'b0; switch = 1'b0; sel_alarm = 1'b0;
    push2 = 1'b1; push3 = 1'b1; snooze = 1'b1;
    alarm_en = 1'b0; sec_tick = 1'b0;
    set_time(0, 0, 0, 0);
    set_alarm(0, 0, 0, 0);
    clear_counts();
    test_reset();
    test_debounce_routing();
    test_ring_timeout();
    test_snooze();
    test_abort_priority();
    test_back_to_back();
    test_reset_mid_ring();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
